// File: rtl/eth_tx_framer_if.sv
// Payload feed and GMII/nibble transmit side of the Ethernet TX framer.
// The producer of payload bytes and the consumer of tx_data are both the master side.
interface eth_tx_framer_if #(
   parameter int LEN_W = 11
);
   logic             i_speed_1g;
   logic             i_start;
   logic [LEN_W-1:0] i_len;
   logic [7:0]       i_pl_data;
   logic             i_pl_valid;
   logic             o_pl_ready;
   logic [7:0]       o_tx_data;
   logic             o_tx_en;
   logic             o_tx_er;
   logic             o_busy;
   logic             o_done;
   logic             o_underrun;

   modport master (
      output i_speed_1g, i_start, i_len, i_pl_data, i_pl_valid,
      input  o_pl_ready, o_tx_data, o_tx_en, o_tx_er, o_busy, o_done, o_underrun
   );

   modport slave (
      input  i_speed_1g, i_start, i_len, i_pl_data, i_pl_valid,
      output o_pl_ready, o_tx_data, o_tx_en, o_tx_er, o_busy, o_done, o_underrun
   );
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble, SFD, payload, zero pad, CRC32 FCS and IFG,
// emitted as GMII bytes (1G) or duplicated nibbles (10/100), all outputs registered.
module eth_tx_framer #(
   parameter int LEN_W     = 11,
   parameter int MIN_LEN   = 60,
   parameter int IFG_BYTES = 12,
   parameter int PRE_BYTES = 7
) (
   input  logic           i_tx_clk,
   input  logic           rst,
   eth_tx_framer_if.slave tx
);
   localparam int CW = LEN_W + 1;
   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW-1:0] PRE_N = CW'(PRE_BYTES);
   localparam logic [CW-1:0] MIN_N = CW'(MIN_LEN);
   localparam logic [CW-1:0] IFG_N = CW'(IFG_BYTES);
   localparam logic [CW-1:0] FCS_N = CW'(4);

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, ERR, IFG} state_t;

   state_t           state;
   logic             m1g;
   logic             ph;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_inc;
   logic [CW-1:0]    len_x;
   logic [LEN_W-1:0] len_q;
   logic [7:0]       byte_q;
   logic [31:0]      crc;
   logic             last;

   assign last    = m1g | ph;
   assign cnt_inc = cnt + ONE;
   assign len_x   = {1'b0, len_q};

   function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
      return r;
   endfunction

   function automatic logic [7:0] fmt(input logic m, input logic [7:0] b);
      return m ? b : {b[3:0], b[3:0]};
   endfunction

   // state is the segment whose byte is currently on tx_data; ph selects its high nibble
   always_ff @(posedge i_tx_clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         m1g            <= 1'b0;
         ph             <= 1'b0;
         cnt            <= '0;
         len_q          <= '0;
         byte_q         <= '0;
         crc            <= 32'hFFFF_FFFF;
         tx.o_tx_data   <= '0;
         tx.o_tx_en     <= 1'b0;
         tx.o_tx_er     <= 1'b0;
         tx.o_busy      <= 1'b0;
         tx.o_done      <= 1'b0;
         tx.o_underrun  <= 1'b0;
         tx.o_pl_ready  <= 1'b0;
      end else begin
         tx.o_done     <= 1'b0;
         tx.o_underrun <= 1'b0;
         if (state == IDLE) begin
            if (tx.i_start) begin
               len_q        <= tx.i_len;
               m1g          <= tx.i_speed_1g;
               ph           <= 1'b0;
               cnt          <= ONE;
               state        <= PRE;
               byte_q       <= 8'h55;
               tx.o_tx_data <= 8'h55;
               tx.o_tx_en   <= 1'b1;
               tx.o_busy    <= 1'b1;
            end
         end else if (!last) begin
            // high nibble; in nibble mode the payload handshake lands here
            ph            <= 1'b1;
            tx.o_tx_data  <= {byte_q[7:4], byte_q[7:4]};
            tx.o_pl_ready <= (state == SFD && len_q != '0) || (state == DATA && cnt < len_x);
            tx.o_done     <= (state == IFG) && (cnt == IFG_N);
         end else begin
            ph            <= 1'b0;
            tx.o_pl_ready <= 1'b0;
            tx.o_tx_en    <= 1'b1;
            tx.o_tx_er    <= 1'b0;
            case (state)
               PRE: begin
                  if (cnt < PRE_N) begin
                     cnt          <= cnt_inc;
                     byte_q       <= 8'h55;
                     tx.o_tx_data <= 8'h55;
                  end else begin
                     state         <= SFD;
                     cnt           <= '0;
                     byte_q        <= 8'hD5;
                     tx.o_tx_data  <= fmt(m1g, 8'hD5);
                     crc           <= 32'hFFFF_FFFF;
                     tx.o_pl_ready <= m1g && (len_q != '0);
                  end
               end
               SFD, DATA, PAD: begin
                  if (tx.o_pl_ready) begin
                     if (tx.i_pl_valid) begin
                        state         <= DATA;
                        cnt           <= cnt_inc;
                        byte_q        <= tx.i_pl_data;
                        tx.o_tx_data  <= fmt(m1g, tx.i_pl_data);
                        crc           <= crc8(crc, tx.i_pl_data);
                        tx.o_pl_ready <= m1g && (cnt_inc < len_x);
                     end else begin
                        state         <= ERR;
                        byte_q        <= '0;
                        tx.o_tx_data  <= '0;
                        tx.o_tx_er    <= 1'b1;
                        tx.o_underrun <= 1'b1;
                     end
                  end else if (cnt < MIN_N) begin
                     state        <= PAD;
                     cnt          <= cnt_inc;
                     byte_q       <= '0;
                     tx.o_tx_data <= '0;
                     crc          <= crc8(crc, 8'h00);
                  end else begin
                     state        <= FCS;
                     cnt          <= ONE;
                     byte_q       <= ~crc[7:0];
                     tx.o_tx_data <= fmt(m1g, ~crc[7:0]);
                     crc          <= {8'h00, crc[31:8]};
                  end
               end
               FCS: begin
                  if (cnt < FCS_N) begin
                     cnt          <= cnt_inc;
                     byte_q       <= ~crc[7:0];
                     tx.o_tx_data <= fmt(m1g, ~crc[7:0]);
                     crc          <= {8'h00, crc[31:8]};
                  end else begin
                     state        <= IFG;
                     cnt          <= ONE;
                     byte_q       <= '0;
                     tx.o_tx_data <= '0;
                     tx.o_tx_en   <= 1'b0;
                     tx.o_done    <= m1g && (IFG_N == ONE);
                  end
               end
               ERR: begin
                  state        <= IFG;
                  cnt          <= ONE;
                  byte_q       <= '0;
                  tx.o_tx_data <= '0;
                  tx.o_tx_en   <= 1'b0;
                  tx.o_done    <= m1g && (IFG_N == ONE);
               end
               IFG: begin
                  tx.o_tx_data <= '0;
                  tx.o_tx_en   <= 1'b0;
                  byte_q       <= '0;
                  if (cnt < IFG_N) begin
                     cnt       <= cnt_inc;
                     tx.o_done <= m1g && (cnt_inc == IFG_N);
                  end else begin
                     state     <= IDLE;
                     cnt       <= '0;
                     tx.o_busy <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: one instance without padding, one padding to 60 bytes,
// expected frame pushed to a scoreboard at start and popped on every tx_en cycle.
module tb_eth_tx_framer;
   localparam int LEN_W = 11;

   typedef struct packed { logic er; logic [7:0] d; } ent_t;

   logic             pll_clk_tx = 1'b0;
   logic             rst;
   logic             sel, start, speed, pl_valid;
   logic [LEN_W-1:0] len;
   logic [7:0]       pl_data;
   logic [7:0]       pl [0:63];
   logic [31:0]      last32;
   ent_t             q[$];
   int               n_total = 0;
   int               n_pass  = 0;
   int               n_fail  = 0;

   always #4 pll_clk_tx = ~pll_clk_tx;

   eth_tx_framer_if #(.LEN_W(LEN_W)) if0 ();
   eth_tx_framer_if #(.LEN_W(LEN_W)) if60 ();

   assign if0.i_start     = start & ~sel;
   assign if60.i_start    = start & sel;
   assign if0.i_speed_1g  = speed;
   assign if60.i_speed_1g = speed;
   assign if0.i_len       = len;
   assign if60.i_len      = len;
   assign if0.i_pl_data   = pl_data;
   assign if60.i_pl_data  = pl_data;
   assign if0.i_pl_valid  = pl_valid;
   assign if60.i_pl_valid = pl_valid;

   logic [7:0] tx_data;
   logic       tx_en, tx_er, busy, done, underrun, pl_ready;
   assign tx_data  = sel ? if60.o_tx_data  : if0.o_tx_data;
   assign tx_en    = sel ? if60.o_tx_en    : if0.o_tx_en;
   assign tx_er    = sel ? if60.o_tx_er    : if0.o_tx_er;
   assign busy     = sel ? if60.o_busy     : if0.o_busy;
   assign done     = sel ? if60.o_done     : if0.o_done;
   assign underrun = sel ? if60.o_underrun : if0.o_underrun;
   assign pl_ready = sel ? if60.o_pl_ready : if0.o_pl_ready;

   eth_tx_framer #(.LEN_W(LEN_W), .MIN_LEN(0), .IFG_BYTES(12), .PRE_BYTES(7)) dut0 (
      .i_tx_clk (pll_clk_tx),
      .rst      (rst),
      .tx       (if0)
   );

   eth_tx_framer #(.LEN_W(LEN_W), .MIN_LEN(60), .IFG_BYTES(12), .PRE_BYTES(7)) dut60 (
      .i_tx_clk (pll_clk_tx),
      .rst      (rst),
      .tx       (if60)
   );

   function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_b(input logic [7:0] b, input logic er, input logic sp);
      ent_t e;
      e.er = er;
      if (sp) begin
         e.d = b;
         q.push_back(e);
      end else begin
         e.d = {b[3:0], b[3:0]};
         q.push_back(e);
         e.d = {b[7:4], b[7:4]};
         q.push_back(e);
      end
   endtask

   // s: 0 = no-pad instance, 1 = pad-to-60 instance; negative drop/restart/rst_at disable that event
   task automatic run_frame(input logic s, input int n, input logic sp, input int drop_at,
                            input int restart_at, input int rst_at, input int exp_en, input int exp_done);
      int          minl, tot, idx, en_cnt, first_en, done_cyc, done_n, busy_gap, er_cnt, urun_cnt;
      logic [31:0] c;
      ent_t        e;
      minl = s ? 60 : 0;
      q.delete();
      for (int i = 0; i < 7; i++) push_b(8'h55, 1'b0, sp);
      push_b(8'hD5, 1'b0, sp);
      c   = 32'hFFFF_FFFF;
      tot = 0;
      for (int i = 0; i < n && i != drop_at; i++) begin
         push_b(pl[i], 1'b0, sp);
         c = crc_ref(c, pl[i]);
         tot++;
      end
      if (drop_at >= 0 && drop_at < n) push_b(8'h00, 1'b1, sp);
      else begin
         while (tot < minl) begin
            push_b(8'h00, 1'b0, sp);
            c = crc_ref(c, 8'h00);
            tot++;
         end
         c = ~c;
         for (int k = 0; k < 4; k++) push_b(c[8*k +: 8], 1'b0, sp);
      end

      idx = 0; en_cnt = 0; first_en = -1; done_cyc = -1; done_n = 0;
      busy_gap = 0; er_cnt = 0; urun_cnt = 0; last32 = '0;
      sel = s; len = n[LEN_W-1:0]; speed = sp; pl_valid = 1'b0;
      @(negedge pll_clk_tx);
      start = 1'b1;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(negedge pll_clk_tx);
         if (cyc == 1) speed = ~speed;
         start = (cyc == restart_at);
         if (tx_en) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last32 = sp ? {tx_data, last32[31:8]} : {tx_data[3:0], last32[31:4]};
            if (q.size() == 0) check("extra_tx_byte", 32'(cyc), 32'(0));
            else begin
               e = q.pop_front();
               check("tx_er", tx_er, e.er);
               if (!e.er) check("tx_data", tx_data, e.d);
            end
         end
         if (tx_er) er_cnt++;
         if (underrun) urun_cnt++;
         if (!busy && done_cyc < 0) busy_gap++;
         if (cyc == rst_at) begin
            rst = 1'b1;
            #1;
            check("rst_tx_en", tx_en, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_tx_data", tx_data, 8'h00);
            @(posedge pll_clk_tx);
            @(negedge pll_clk_tx);
            rst = 1'b0;
            pl_valid = 1'b0;
            start = 1'b0;
            q.delete();
            return;
         end
         if (done) begin
            done_n++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            check("busy_after_done", busy, 1'b0);
            check("tx_en_after_done", tx_en, 1'b0);
            break;
         end
         if (pl_ready) begin
            pl_valid = (idx != drop_at);
            pl_data  = pl[idx[5:0]];
            if (pl_valid) idx++;
         end else pl_valid = 1'b0;
      end
      pl_valid = 1'b0;
      start    = 1'b0;
      check("first_tx_en_cycle", 32'(first_en), 32'(1));
      check("tx_en_cycles", 32'(en_cnt), 32'(exp_en));
      check("done_cycle", 32'(done_cyc), 32'(exp_done));
      check("done_pulses", 32'(done_n), 32'(1));
      check("busy_gaps", 32'(busy_gap), 32'(0));
      check("underrun_pulses", 32'(urun_cnt), (drop_at >= 0) ? 32'(1) : 32'(0));
      check("tx_er_cycles", 32'(er_cnt), (drop_at >= 0) ? (sp ? 32'(1) : 32'(2)) : 32'(0));
      check("scoreboard_left", 32'(q.size()), 32'(0));
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; start = 1'b0; speed = 1'b1; pl_valid = 1'b0;
      len = '0; pl_data = '0; last32 = '0;
      repeat (3) @(posedge pll_clk_tx);
      @(negedge pll_clk_tx);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("reset_tx_en", tx_en, 1'b0);
         check("reset_tx_er", tx_er, 1'b0);
         check("reset_tx_data", tx_data, 8'h00);
         check("reset_busy", busy, 1'b0);
         check("reset_done", done, 1'b0);
         check("reset_underrun", underrun, 1'b0);
         check("reset_pl_ready", pl_ready, 1'b0);
      end
      sel = 1'b0;
      rst = 1'b0;

      // "123456789" at 1G, no padding
      for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
      run_frame(1'b0, 9, 1'b1, -1, -1, -1, 21, 33);
      check("fcs_1g_bytes", last32, 32'hCBF4_3926);

      // ten 0xAA bytes padded to 60
      for (int i = 0; i < 10; i++) pl[i] = 8'hAA;
      run_frame(1'b1, 10, 1'b1, -1, -1, -1, 72, 84);

      // same 9-byte frame in nibble mode
      for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
      run_frame(1'b0, 9, 1'b0, -1, -1, -1, 42, 66);
      check("fcs_nibbles", last32, 32'hCBF4_3926);

      // valid dropped at payload byte 5 of 20
      for (int i = 0; i < 20; i++) pl[i] = 8'($urandom);
      run_frame(1'b0, 20, 1'b1, 5, -1, -1, 14, 26);

      // frame right after an underrun
      for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
      run_frame(1'b0, 16, 1'b1, -1, -1, -1, 28, 40);

      // zero-length payload padded to 60, second start mid-frame
      run_frame(1'b1, 0, 1'b1, -1, 10, -1, 72, 84);

      // reset during FCS, then a nibble-mode frame from scratch
      for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
      run_frame(1'b0, 9, 1'b1, -1, -1, 19, 0, 0);
      for (int i = 0; i < 12; i++) pl[i] = 8'($urandom);
      run_frame(1'b0, 12, 1'b0, -1, -1, -1, 48, 72);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
